// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: hex glyph table and decode helper for the seven-segment scan driver.
package seven_seg_pkg;

    localparam logic [6:0] SEG_HEX_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [7:0] SEG_OFF = 8'h00;

    function automatic logic [6:0] seg_hex_decode(input logic [3:0] nibble);
        return SEG_HEX_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seven_seg_refresh_timer.sv
// seven_seg_refresh_timer: slot divider, digit scan index, guard window and frame-boundary strobe.
module seven_seg_refresh_timer #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 262144,
    parameter int GUARD_CYCLES = 16,
    localparam int DW = $clog2(CLK_DIV),
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic          cmosClock,
    input  logic          resetN,
    output logic [IW-1:0] digitIdx,
    output logic          guard,
    output logic          frameBoundary
);

    logic [DW-1:0] divider;
    logic          slotTick;
    logic          lastDigit;

    assign slotTick      = divider == DW'(CLK_DIV - 1);
    assign lastDigit     = digitIdx == IW'(NUM_DIGITS - 1);
    assign frameBoundary = slotTick && lastDigit;
    assign guard         = int'(divider) < GUARD_CYCLES;

    always_ff @(posedge cmosClock or negedge resetN) begin
        if (!resetN) begin
            divider  <= '0;
            digitIdx <= '0;
        end else begin
            divider <= slotTick ? '0 : divider + 1'b1;
            if (slotTick)
                digitIdx <= lastDigit ? '0 : digitIdx + 1'b1;
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: multiplexed hex display driver with frame-synchronous double buffering.
// Optional leading-zero suppression when SEVEN_SEG_LEADING_ZERO_BLANK_EN is defined.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 262144,
    parameter int GUARD_CYCLES = 16,
    parameter int ACTIVE_LOW   = 1,
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    cmosClock,
    input  logic                    resetN,
    input  logic                    loadValid,
    input  logic [4*NUM_DIGITS-1:0] loadValue,
    input  logic [NUM_DIGITS-1:0]   loadDp,
    input  logic [NUM_DIGITS-1:0]   loadBlank,
    output logic [NUM_DIGITS-1:0]   sevenSegmentEnable,
    output logic [7:0]              sevenSegmentData,
    output logic                    frameDone,
    output logic                    pendingBusy
);

    localparam logic [NUM_DIGITS-1:0] EN_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]            DATA_OFF = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;

    logic [IW-1:0]           digitIdx;
    logic                    guard;
    logic                    frameBoundary;
    logic [4*NUM_DIGITS-1:0] pendValue, shadowValue;
    logic [NUM_DIGITS-1:0]   pendDp, shadowDp;
    logic [NUM_DIGITS-1:0]   pendBlank, shadowBlank;
    logic [NUM_DIGITS-1:0]   autoBlank;
    logic [NUM_DIGITS-1:0]   enActive;
    logic [7:0]              dataActive;
    logic [3:0]              nibble;
    logic                    digitBlank;

    seven_seg_refresh_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .CLK_DIV     (CLK_DIV),
        .GUARD_CYCLES(GUARD_CYCLES)
    ) timer (
        .cmosClock    (cmosClock),
        .resetN       (resetN),
        .digitIdx     (digitIdx),
        .guard        (guard),
        .frameBoundary(frameBoundary)
    );

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // Walk down from the top digit; suppression stops at the first non-zero nibble or lit DP.
    always_comb begin
        logic keep;
        keep      = 1'b0;
        autoBlank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            keep         = keep | (shadowValue[4*i +: 4] != 4'h0) | shadowDp[i];
            autoBlank[i] = !keep;
        end
    end
`else
    assign autoBlank = '0;
`endif

    always_comb begin
        nibble     = shadowValue[4*digitIdx +: 4];
        digitBlank = shadowBlank[digitIdx] | autoBlank[digitIdx];
        enActive   = guard ? '0 : NUM_DIGITS'(1) << digitIdx;
        dataActive = (guard || digitBlank) ? SEG_OFF : {shadowDp[digitIdx], seg_hex_decode(nibble)};
    end

    always_ff @(posedge cmosClock or negedge resetN) begin
        if (!resetN) begin
            pendValue          <= '0;
            pendDp             <= '0;
            pendBlank          <= '0;
            shadowValue        <= '0;
            shadowDp           <= '0;
            shadowBlank        <= '0;
            pendingBusy        <= 1'b0;
            frameDone          <= 1'b0;
            sevenSegmentEnable <= EN_OFF;
            sevenSegmentData   <= DATA_OFF;
        end else begin
            if (loadValid) begin
                pendValue <= loadValue;
                pendDp    <= loadDp;
                pendBlank <= loadBlank;
            end
            // A load landing on the boundary bypasses pending and goes live immediately.
            if (frameBoundary && loadValid) begin
                shadowValue <= loadValue;
                shadowDp    <= loadDp;
                shadowBlank <= loadBlank;
            end else if (frameBoundary && pendingBusy) begin
                shadowValue <= pendValue;
                shadowDp    <= pendDp;
                shadowBlank <= pendBlank;
            end
            pendingBusy        <= frameBoundary ? 1'b0 : (pendingBusy | loadValid);
            frameDone          <= frameBoundary;
            sevenSegmentEnable <= enActive ^ EN_OFF;
            sevenSegmentData   <= dataActive ^ DATA_OFF;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: directed checks of scan order, glyphs, commit timing, blanking and reset.
module tb_seven_seg_scan_driver;

    logic        cmosClock = 1'b0;
    logic        resetN = 1'b0;
    logic        loadValid = 1'b0;
    logic [15:0] loadValue = '0;
    logic [3:0]  loadDp = '0;
    logic [3:0]  loadBlank = '0;
    logic [3:0]  sevenSegmentEnable;
    logic [7:0]  sevenSegmentData;
    logic        frameDone;
    logic        pendingBusy;
    int          checks = 0;
    int          failures = 0;

    always #5 cmosClock = ~cmosClock;

    seven_seg_scan_driver #(
        .NUM_DIGITS  (4),
        .CLK_DIV     (4),
        .GUARD_CYCLES(1),
        .ACTIVE_LOW  (1)
    ) dut (
        .cmosClock         (cmosClock),
        .resetN            (resetN),
        .loadValid         (loadValid),
        .loadValue         (loadValue),
        .loadDp            (loadDp),
        .loadBlank         (loadBlank),
        .sevenSegmentEnable(sevenSegmentEnable),
        .sevenSegmentData  (sevenSegmentData),
        .frameDone         (frameDone),
        .pendingBusy       (pendingBusy)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge cmosClock);
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] blank);
        loadValue = v;
        loadDp    = dp;
        loadBlank = blank;
        loadValid = 1'b1;
        tick(1);
        loadValid = 1'b0;
    endtask

    task automatic waitFrame();
        int n;
        n = 0;
        @(negedge cmosClock);
        while (!frameDone && n < 40) begin
            @(negedge cmosClock);
            n++;
        end
        check("frameSync", 16'(frameDone), 16'h1);
    endtask

    // Entered on the cycle frameDone is high; leaves on the next frameDone cycle.
    task automatic scanFrame(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] exp [4];
        logic [3:0] en;
        exp[0] = d0; exp[1] = d1; exp[2] = d2; exp[3] = d3;
        for (int d = 0; d < 4; d++) begin
            tick(1);
            check($sformatf("guardEn%0d", d), 16'(sevenSegmentEnable), 16'hF);
            check($sformatf("guardData%0d", d), 16'(sevenSegmentData), 16'hFF);
            check($sformatf("frameDoneLow%0d", d), 16'(frameDone), 16'h0);
            tick(1);
            en = ~(4'b0001 << d);
            check($sformatf("slotEn%0d", d), 16'(sevenSegmentEnable), 16'(en));
            check($sformatf("slotData%0d", d), 16'(sevenSegmentData), 16'(exp[d]));
            tick(2);
        end
        check("framePulse", 16'(frameDone), 16'h1);
    endtask

    initial begin
        tick(2);
        check("rstEn", 16'(sevenSegmentEnable), 16'hF);
        check("rstData", 16'(sevenSegmentData), 16'hFF);
        check("rstFrameDone", 16'(frameDone), 16'h0);
        check("rstBusy", 16'(pendingBusy), 16'h0);
        resetN = 1'b1;
        tick(1);
        check("firstGuardEn", 16'(sevenSegmentEnable), 16'hF);
        tick(1);
        check("firstSlotEn", 16'(sevenSegmentEnable), 16'hE);
        check("firstSlotData", 16'(sevenSegmentData), 16'hC0);

        load(16'h1234, 4'b0000, 4'b0000);
        check("busyAfterLoad", 16'(pendingBusy), 16'h1);
        waitFrame();
        check("busyAfterCommit", 16'(pendingBusy), 16'h0);
        scanFrame(8'h99, 8'hB0, 8'hA4, 8'hF9);

        tick(6);
        load(16'hABCD, 4'b0000, 4'b0000);
        check("tearBusy", 16'(pendingBusy), 16'h1);
        tick(3);
        check("tearEn2", 16'(sevenSegmentEnable), 16'hB);
        check("tearData2", 16'(sevenSegmentData), 16'hA4);
        tick(4);
        check("tearEn3", 16'(sevenSegmentEnable), 16'h7);
        check("tearData3", 16'(sevenSegmentData), 16'hF9);
        check("tearBusyLate", 16'(pendingBusy), 16'h1);
        tick(2);
        check("tearBoundary", 16'(frameDone), 16'h1);
        check("tearBusyClear", 16'(pendingBusy), 16'h0);
        scanFrame(8'hA1, 8'hC6, 8'h83, 8'h88);

        tick(2);
        load(16'h1111, 4'b0000, 4'b0000);
        tick(3);
        load(16'h2222, 4'b0000, 4'b0000);
        check("collBusy", 16'(pendingBusy), 16'h1);
        tick(8);
        load(16'h3333, 4'b0000, 4'b0000);
        check("collBoundary", 16'(frameDone), 16'h1);
        check("collBusyClear", 16'(pendingBusy), 16'h0);
        scanFrame(8'hB0, 8'hB0, 8'hB0, 8'hB0);

        load(16'h1234, 4'b0001, 4'b0100);
        waitFrame();
        scanFrame(8'h19, 8'hB0, 8'hFF, 8'hF9);

        load(16'h0042, 4'b0000, 4'b0000);
        waitFrame();
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        scanFrame(8'hA4, 8'h99, 8'hFF, 8'hFF);
`else
        scanFrame(8'hA4, 8'h99, 8'hC0, 8'hC0);
`endif
        load(16'h0000, 4'b0000, 4'b0000);
        waitFrame();
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        scanFrame(8'hC0, 8'hFF, 8'hFF, 8'hFF);
`else
        scanFrame(8'hC0, 8'hC0, 8'hC0, 8'hC0);
`endif

        tick(6);
        check("preResetEn", 16'(sevenSegmentEnable), 16'hD);
        #2 resetN = 1'b0;
        #1;
        check("midRstEn", 16'(sevenSegmentEnable), 16'hF);
        check("midRstData", 16'(sevenSegmentData), 16'hFF);
        check("midRstBusy", 16'(pendingBusy), 16'h0);
        @(negedge cmosClock);
        resetN = 1'b1;
        tick(1);
        check("restartGuard", 16'(sevenSegmentEnable), 16'hF);
        tick(1);
        check("restartEn", 16'(sevenSegmentEnable), 16'hE);
        check("restartData", 16'(sevenSegmentData), 16'hC0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
